// File: rtl/pwm_gen_pkg.sv
// Shared defaults, types and helpers for the PWM serializer word generator.
package pwm_gen_pkg;
    localparam int SER_DEF  = 8;
    localparam int CW_DEF   = 16;
    localparam int FRAC_DEF = 4;

    typedef logic [CW_DEF+FRAC_DEF-1:0] duty_t;
    typedef logic [CW_DEF-1:0]          period_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pwm_word_cmp.sv
// One channel's SER-bit output word for the current phase; bit 0 leaves first.
module pwm_word_cmp
    import pwm_gen_pkg::*;
#(
    parameter int SER = SER_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic [CW-1:0]  ph_i,
    input  logic [CW-1:0]  per_act_i,
    input  logic [CW-1:0]  duty_act_i,
    input  logic [CW-1:0]  duty_sh_i,
    output logic [SER-1:0] word_o
);
    for (genvar i = 0; i < SER; i++) begin : g_bit
        logic [CW:0] pos_abs;
        logic [CW:0] pos_rel;
        logic        wrapped;

        assign pos_abs = {1'b0, ph_i} + (CW+1)'(i);
        assign wrapped = pos_abs >= {1'b0, per_act_i};
        // Bits past the frame end already belong to the next frame and its duty.
        assign pos_rel = wrapped ? pos_abs - {1'b0, per_act_i} : pos_abs;
        assign word_o[i] = wrapped ? (pos_rel < {1'b0, duty_sh_i})
                                   : (pos_rel < {1'b0, duty_act_i});
    end
endmodule

// File: rtl/pwm_serdes_gen.sv
// Multi-channel PWM word generator for an SER:1 serializer with shadowed config.
// Optional frame-to-frame duty dithering is built when PWM_DITHER_EN is defined.
module pwm_serdes_gen
    import pwm_gen_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int SER        = SER_DEF,
    parameter int CW         = CW_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int PERIOD_RST = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cfg_period_we,
    input  logic [CW-1:0]              cfg_period,
    input  logic                       cfg_duty_we,
    input  logic [clog2_min1(NCH)-1:0] cfg_ch,
    input  logic [CW+FRAC-1:0]         cfg_duty,
    output logic [NCH*SER-1:0]         pwm_word,
    output logic                       frame_start
);
    localparam logic [CW:0]   SER_W   = (CW+1)'(SER);
    localparam logic [CW-1:0] SER_P   = CW'(SER);
    localparam logic [CW-1:0] PER_RST = CW'(PERIOD_RST);

    logic [CW-1:0]      ph_q, ph_d;
    logic [CW-1:0]      per_act_q, per_sh_q, per_promo;
    logic [CW:0]        ph_sum;
    logic               boundary, wrap_word, promote;
    logic [NCH*SER-1:0] word_d, pwm_word_q;
    logic               frame_start_q;

    assign ph_sum    = {1'b0, ph_q} + SER_W;
    // The edge after the last word of a frame promotes, so the next frame's
    // first bit (wrapped or at ph=0) already sees the new settings.
    assign boundary  = ph_sum >= {1'b0, per_act_q};
    assign wrap_word = ph_sum > {1'b0, per_act_q};
    assign promote   = !en || boundary;
    assign per_promo = (per_sh_q < SER_P) ? SER_P : per_sh_q;

    always_comb begin
        ph_d = ph_sum[CW-1:0];
        if (!en) begin
            ph_d = '0;
        end else if (boundary) begin
            ph_d = CW'(ph_sum - {1'b0, per_act_q});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q      <= '0;
            per_act_q <= PER_RST;
            per_sh_q  <= PER_RST;
        end else begin
            ph_q <= ph_d;
            if (cfg_period_we) per_sh_q <= cfg_period;
            if (promote) per_act_q <= per_promo;
        end
    end

`ifndef PWM_DITHER_EN
    logic unused_frac;
    assign unused_frac = ^cfg_duty[FRAC-1:0];
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] duty_act_q, duty_sh_q, duty_nxt;
        logic          sel;

        assign sel = cfg_duty_we && (32'(cfg_ch) == 32'(c));

`ifdef PWM_DITHER_EN
        logic [FRAC-1:0] frac_sh_q, acc_q;
        logic [FRAC:0]   acc_sum;
        logic [CW:0]     duty_inc;

        assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_sh_q};
        assign duty_inc = {1'b0, duty_sh_q} + (CW+1)'(acc_sum[FRAC] & en);
        assign duty_nxt = (duty_inc > {1'b0, per_promo}) ? per_promo : duty_inc[CW-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                frac_sh_q <= '0;
                acc_q     <= '0;
            end else begin
                if (sel) frac_sh_q <= cfg_duty[FRAC-1:0];
                if (!en) begin
                    acc_q <= '0;
                end else if (boundary) begin
                    acc_q <= acc_sum[FRAC-1:0];
                end
            end
        end
`else
        assign duty_nxt = duty_sh_q;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_sh_q  <= '0;
                duty_act_q <= '0;
            end else begin
                if (sel) duty_sh_q <= cfg_duty[CW+FRAC-1:FRAC];
                if (promote) duty_act_q <= duty_nxt;
            end
        end

        pwm_word_cmp #(
            .SER (SER),
            .CW  (CW)
        ) u_cmp (
            .ph_i       (ph_q),
            .per_act_i  (per_act_q),
            .duty_act_i (duty_act_q),
            .duty_sh_i  (duty_nxt),
            .word_o     (word_d[c*SER +: SER])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pwm_word_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pwm_word_q    <= word_d;
            frame_start_q <= (ph_q == '0) || wrap_word;
        end
    end

    assign pwm_word    = pwm_word_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_pwm_serdes_gen.sv
// Scoreboard bench for pwm_serdes_gen: a bit-serial frame model predicts every word.
module tb_pwm_serdes_gen;
    localparam int NCH  = 2;
    localparam int SER  = 8;
    localparam int CW   = 16;
    localparam int FRAC = 4;
    localparam int PRST = 256;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 cfg_period_we = 1'b0;
    logic [CW-1:0]        cfg_period = '0;
    logic                 cfg_duty_we = 1'b0;
    logic [0:0]           cfg_ch = '0;
    logic [CW+FRAC-1:0]   cfg_duty = '0;
    logic [NCH*SER-1:0]   pwm_word;
    logic                 frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_serdes_gen #(
        .NCH(NCH), .SER(SER), .CW(CW), .FRAC(FRAC), .PERIOD_RST(PRST)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_period_we(cfg_period_we), .cfg_period(cfg_period),
        .cfg_duty_we(cfg_duty_we), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
        .pwm_word(pwm_word), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*SER-1:0] word;
        logic               fs;
    } exp_t;
    exp_t sb_q[$];

    // Reference: frames are walked one fast bit at a time.
    int m_pos, m_per, m_per_sh;
    int m_duty[NCH];
    int m_duty_sh[NCH];
    int m_acc[NCH];

    function automatic void model_reset();
        m_pos = 0;
        m_per = PRST;
        m_per_sh = PRST;
        for (int c = 0; c < NCH; c++) begin
            m_duty[c] = 0;
            m_duty_sh[c] = 0;
            m_acc[c] = 0;
        end
    endfunction

    function automatic void new_frame(input bit en_now);
        m_per = (m_per_sh < SER) ? SER : m_per_sh;
        m_pos = 0;
        for (int c = 0; c < NCH; c++) begin
            int d;
            d = m_duty_sh[c] >> FRAC;
`ifdef PWM_DITHER_EN
            if (en_now) begin
                m_acc[c] += m_duty_sh[c] % (1 << FRAC);
                if (m_acc[c] >= (1 << FRAC)) begin
                    m_acc[c] -= (1 << FRAC);
                    d = d + 1;
                    if (d > m_per) d = m_per;
                end
            end else begin
                m_acc[c] = 0;
            end
`else
            if (en_now) m_acc[c] = 0;
`endif
            m_duty[c] = d;
        end
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e.word = '0;
        e.fs   = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!en) begin
            new_frame(1'b0);
        end else begin
            for (int i = 0; i < SER; i++) begin
                if (m_pos >= m_per) new_frame(1'b1);
                if (m_pos == 0) e.fs = 1'b1;
                for (int c = 0; c < NCH; c++)
                    if (m_pos < m_duty[c]) e.word[c*SER + i] = 1'b1;
                m_pos++;
            end
            if (m_pos >= m_per) new_frame(1'b1);
        end
        if (!rst) begin
            if (cfg_period_we) m_per_sh = int'(cfg_period);
            if (cfg_duty_we) m_duty_sh[cfg_ch] = int'(cfg_duty);
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (pwm_word !== e.word) begin
                n_fail++;
                $display("FAIL sb_word @%0t: got %h, expected %h", $time, pwm_word, e.word);
            end
            n_checks++;
            if (frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL sb_frame_start @%0t: got %b, expected %b", $time, frame_start, e.fs);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Program period and both duties with the generator stopped, then let them promote.
    task automatic setup(input int p, input int d0, input int d1);
        en = 1'b0;
        cfg_period_we = 1'b1; cfg_period = CW'(p);
        cfg_duty_we = 1'b1; cfg_ch = 1'b0; cfg_duty = (CW+FRAC)'(d0);
        @(negedge clk);
        cfg_period_we = 1'b0;
        cfg_ch = 1'b1; cfg_duty = (CW+FRAC)'(d1);
        @(negedge clk);
        cfg_duty_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [7:0] seq_b[5] = '{8'hFF, 8'h03, 8'hF0, 8'h3F, 8'h00};
    logic       fs_b[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_word", 32'(pwm_word), 32'h0);
        chk("reset_fs", 32'(frame_start), 32'h0);
        rst = 1'b0;

        // 256-bit period, ch0 duty 64, ch1 off
        setup(256, 64 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("A_ch0", 32'(pwm_word[7:0]), (k % 32 < 8) ? 32'hFF : 32'h00);
            chk("A_fs", 32'(frame_start), 32'(k % 32 == 0));
            chk("A_ch1", 32'(pwm_word[15:8]), 32'h0);
        end

        // 20-bit period, words straddle frame ends
        setup(20, 10 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("B_ch0", 32'(pwm_word[7:0]), 32'(seq_b[k % 5]));
            chk("B_fs", 32'(frame_start), 32'(fs_b[k % 5]));
        end

        // Duty change mid-frame takes effect from the next frame only
        setup(256, 64 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k < 32) chk("C_old", 32'(pwm_word[7:0]), (k < 8) ? 32'hFF : 32'h00);
            else        chk("C_new", 32'(pwm_word[7:0]), (k - 32 < 25) ? 32'hFF : 32'h00);
            if (k == 10) begin
                cfg_duty_we = 1'b1; cfg_ch = 1'b0; cfg_duty = (CW+FRAC)'(200 << FRAC);
            end
            if (k == 11) cfg_duty_we = 1'b0;
        end

        // Duty beyond the period, then a period below SER
        setup(256, 300 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("D_full", 32'(pwm_word[7:0]), 32'hFF);
        end
        setup(3, 4 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("D_clamp", 32'(pwm_word[7:0]), 32'h0F);
            chk("D_clamp_fs", 32'(frame_start), 32'h1);
        end

        // Enable dropped mid-frame, then restored
        setup(256, 64 << FRAC, 0);
        en = 1'b1;
        for (int k = 0; k < 12; k++) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("E_low", 32'(pwm_word), 32'h0);
        end
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("E_restart", 32'(pwm_word[7:0]), 32'hFF);
            chk("E_fs", 32'(frame_start), 32'(k == 0));
        end

`ifdef PWM_DITHER_EN
        begin
            int n10, n11, hi;
            n10 = 0; n11 = 0;
            setup(64, (10 << FRAC) + 4, 0);
            en = 1'b1;
            for (int k = 0; k < 8; k++) @(negedge clk);
            for (int f = 0; f < 16; f++) begin
                hi = 0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    hi += $countones(pwm_word[7:0]);
                end
                if (hi == 10) n10++;
                if (hi == 11) n11++;
            end
            chk("dither_11", 32'(n11), 32'd4);
            chk("dither_10", 32'(n10), 32'd12);
        end
`endif

        // Randomized traffic: config writes, enable toggles, occasional reset
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 149) == 0) en = ~en;
            cfg_period_we = (r < 3);
            cfg_period = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(0, 40))
                                                      : CW'($urandom_range(41, 400));
            cfg_duty_we = (r == 1) || (r >= 3 && r < 15);
            cfg_ch = 1'($urandom_range(0, 1));
            cfg_duty = (CW+FRAC)'($urandom_range(0, 450) * 16 + $urandom_range(0, 15));
            @(negedge clk);
        end
        rst = 1'b0;
        cfg_period_we = 1'b0;
        cfg_duty_we = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
